cache_req_frontend: RTL

// Upstream request stage for the cache controller. Accepts CPU addresses, splits them into tag/index,

---
 rtl/cache_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/cache_req_frontend.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache request front end.
package cache_pkg;

    localparam int unsigned TAG_W_DEF = 16;
    localparam int unsigned IDX_W_DEF = 10;
    localparam int unsigned STAT_W    = 32;

    typedef struct packed {
        logic [TAG_W_DEF-1:0] tag;
        logic [IDX_W_DEF-1:0] index;
    } req_t;

    typedef enum logic [0:0] {
        TRK_IDLE = 1'b0,
        TRK_BUSY = 1'b1
    } tracker_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy output and a flush that empties it in one cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign level_o = level_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cache_req_frontend.sv
// Cache request front end: address split, request FIFO, single in-flight lookup
// tracker and saturating hit/miss statistics.
module cache_req_frontend
    import cache_pkg::*;
#(
    parameter int unsigned index_width  = IDX_W_DEF,
    parameter int unsigned tag_width    = TAG_W_DEF,
    parameter int unsigned offset_width = 4,
    parameter int unsigned depth        = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     req_valid_i,
    input  logic [tag_width+index_width+offset_width-1:0] req_addr_i,
    output logic                                     req_ready_o,
    input  logic                                     flush_i,
    output logic                                     it_valid_o,
    input  logic                                     it_ready_i,
    output logic [tag_width-1:0]                     tag_o,
    output logic [index_width-1:0]                   index_o,
    input  logic                                     hm_valid_i,
    input  logic                                     hm_ready_i,
    input  logic                                     hit_miss_i,
    output logic                                     busy_o,
    output logic [tag_width-1:0]                     inflight_tag_o,
    output logic [index_width-1:0]                   inflight_idx_o,
    output logic [$clog2(depth):0]                   level_o,
    input  logic                                     clr_stats_i,
    output logic [STAT_W-1:0]                        hit_cnt_o,
    output logic [STAT_W-1:0]                        miss_cnt_o
);

    localparam int unsigned ADDR_W = tag_width + index_width + offset_width;
    localparam int unsigned ENT_W  = tag_width + index_width;

    tracker_state_t          state_q, state_d;
    logic [ENT_W-1:0]        wr_entry, head;
    logic [ENT_W-1:0]        inflight_q, inflight_d;
    logic [STAT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0]       miss_cnt_q, miss_cnt_d;
    logic                    fifo_full, fifo_empty;
    logic                    issue, hm_fire;
    logic                    unused_offset;

    assign wr_entry      = req_addr_i[ADDR_W-1 -: ENT_W];
    assign unused_offset = ^req_addr_i[offset_width-1:0];

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (req_valid_i),
        .pop_i   (issue),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign req_ready_o = ~fifo_full;
    assign {tag_o, index_o} = head;
    assign issue   = it_valid_o & it_ready_i;
    assign hm_fire = busy_o & hm_valid_i & hm_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= TRK_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRK_IDLE: if (issue)   state_d = TRK_BUSY;
            TRK_BUSY: if (hm_fire) state_d = TRK_IDLE;
            default:               state_d = TRK_IDLE;
        endcase
    end

    always_comb begin
        it_valid_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            TRK_IDLE: it_valid_o = ~fifo_empty;
            TRK_BUSY: busy_o     = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        inflight_d = issue ? head : inflight_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr_stats_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (hm_fire) begin
            if (hit_miss_i && hit_cnt_q != '1)        hit_cnt_d  = hit_cnt_q + STAT_W'(1);
            else if (!hit_miss_i && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign {inflight_tag_o, inflight_idx_o} = inflight_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

    // A result handshake with no lookup outstanding is a controller protocol error.
    a_no_result_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        !(hm_valid_i && hm_ready_i && state_q == TRK_IDLE));

endmodule
